vga_pattern_fill: RTL and testbench

- Hardware fill engine for the VGA framebuffer RAM.
- Paints a rectangular region with solid, vertical-stripe, horizontal-stripe or checker patterns from a small colour table, in raster order.
- Replaces CPU-driven loops of single-pixel VGA writes.
- Sits between the CPU (start/done handshake) and the video RAM write port (valid/ready).

---
 rtl/vga_pattern_fill_pkg.sv | 27 ++
 rtl/vga_pattern_fill_stripe_counter.sv | 56 +++++
 rtl/vga_pattern_fill.sv | 240 ++++++++++++++++++++++++
 tb/tb_vga_pattern_fill.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_fill_pkg.sv
// Shared definitions for the VGA rectangle fill engine: colour constants,
// fill-mode and FSM encodings.
package vga_pattern_fill_pkg;

  localparam logic [2:0] COLOR_BLACK   = 3'd0;
  localparam logic [2:0] COLOR_BLUE    = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_CYAN    = 3'd3;
  localparam logic [2:0] COLOR_RED     = 3'd4;
  localparam logic [2:0] COLOR_MAGENTA = 3'd5;
  localparam logic [2:0] COLOR_YELLOW  = 3'd6;
  localparam logic [2:0] COLOR_WHITE   = 3'd7;

  typedef enum logic [1:0] {
    FILL_SOLID   = 2'd0,
    FILL_VSTRIPE = 2'd1,
    FILL_HSTRIPE = 2'd2,
    FILL_CHECKER = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vga_pattern_fill_stripe_counter.sv
// Pixel-within-stripe counter with a stripe index that wraps at the active
// colour-table size. Exposes the next index so the owner can register pixel data.
module stripe_counter
  import vga_pattern_fill_pkg::*;
#(
  parameter int CW = 8,
  parameter int IW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          step_i,
  input  logic [CW-1:0] width_i,
  input  logic [IW:0]   nstripes_i,
  output logic [IW-1:0] idx_next_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   idx_inc_s;

  // Next count/index; clear has priority over step.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    idx_inc_s = {1'b0, idx_q} + {{IW{1'b0}}, 1'b1};
    if (clear_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      if (cnt_q >= width_i - CW'(1)) begin
        cnt_d = '0;
        idx_d = (idx_inc_s >= nstripes_i) ? '0 : idx_inc_s[IW-1:0];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
      idx_d = idx_q;
    end
  end

  assign idx_next_o = idx_d;

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/vga_pattern_fill.sv
// Rectangle fill engine: walks a clamped region in raster order and streams
// patterned pixels to the framebuffer write port under valid/ready.
module vga_pattern_fill
  import vga_pattern_fill_pkg::*;
#(
  parameter int COLS     = 256,
  parameter int ROWS     = 64,
  parameter int COLOR_W  = 3,
  parameter int NSTRIPES = 4,
  parameter int XW       = 8,
  parameter int YW       = 6,
  parameter int AW       = 14
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iStart,
  input  logic [1:0]                    iMode,
  input  logic [NSTRIPES*COLOR_W-1:0]   iColorTable,
  input  logic [$clog2(NSTRIPES):0]     iNumStripes,
  input  logic [XW-1:0]                 iStripeW,
  input  logic [XW-1:0]                 iX0,
  input  logic [XW-1:0]                 iX1,
  input  logic [YW-1:0]                 iY0,
  input  logic [YW-1:0]                 iY1,
  input  logic                          iWrReady,
  output logic                          oWrEn,
  output logic [AW-1:0]                 oWrAddr,
  output logic [COLOR_W-1:0]            oWrData,
  output logic                          oBusy,
  output logic                          oDone
);

  // NSTRIPES must be a power of two and at least 2.
  localparam int IW = $clog2(NSTRIPES);
  localparam int NW = IW + 1;
  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

  function automatic logic [AW-1:0] pixel_addr(input logic [YW-1:0] row,
                                               input logic [XW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  function automatic logic [COLOR_W-1:0] table_entry(input logic [NSTRIPES*COLOR_W-1:0] tbl,
                                                     input logic [IW-1:0] idx);
    return tbl[idx*COLOR_W +: COLOR_W];
  endfunction

  fill_state_e               state_q, state_d;
  fill_mode_e                mode_q;
  logic [NSTRIPES*COLOR_W-1:0] table_q;
  logic [NW-1:0]             nstr_q;
  logic [XW-1:0]             sw_q, x0_q, x1_q, col_q, col_d;
  logic [YW-1:0]             y1_q, row_q, row_d;
  logic                      wr_en_q, wr_en_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [COLOR_W-1:0]        data_q, data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [XW-1:0] x1_clamp_s, sw_in_s;
  logic [YW-1:0] y1_clamp_s;
  logic [NW-1:0] nstr_in_s, chk_sum_s;
  logic [IW-1:0] xs_next_s, ys_next_s, idx_sel_s;
  logic          start_s, accept_s, row_end_s, last_s, empty_s;

  assign x1_clamp_s = (iX1 > XMAX) ? XMAX : iX1;
  assign y1_clamp_s = (iY1 > YMAX) ? YMAX : iY1;
  assign sw_in_s    = (iStripeW == '0) ? XW'(1) : iStripeW;
  assign nstr_in_s  = (iNumStripes == '0)           ? NW'(1) :
                      (iNumStripes > NW'(NSTRIPES)) ? NW'(NSTRIPES) : iNumStripes;
  assign empty_s    = (iX0 > x1_clamp_s) || (iY0 > y1_clamp_s);

  assign start_s   = (state_q == ST_IDLE) && iStart;
  assign accept_s  = (state_q == ST_WRITE) && iWrReady;
  assign row_end_s = (col_q == x1_q);
  assign last_s    = row_end_s && (row_q == y1_q);

  stripe_counter #(.CW(XW), .IW(IW)) u_xstripe (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .clear_i    (start_s || (accept_s && row_end_s)),
    .step_i     (accept_s),
    .width_i    (sw_q),
    .nstripes_i (nstr_q),
    .idx_next_o (xs_next_s)
  );

  stripe_counter #(.CW(XW), .IW(IW)) u_ystripe (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .clear_i    (start_s),
    .step_i     (accept_s && row_end_s),
    .width_i    (sw_q),
    .nstripes_i (nstr_q),
    .idx_next_o (ys_next_s)
  );

  // Colour index of the pixel about to be presented; indices are < nstr_q so
  // the checker sum needs at most one subtraction.
  always_comb begin
    chk_sum_s = NW'(xs_next_s) + NW'(ys_next_s);
    idx_sel_s = '0;
    case (mode_q)
      FILL_SOLID:   idx_sel_s = '0;
      FILL_VSTRIPE: idx_sel_s = xs_next_s;
      FILL_HSTRIPE: idx_sel_s = ys_next_s;
      FILL_CHECKER: begin
        if (chk_sum_s >= nstr_q) begin
          idx_sel_s = IW'(chk_sum_s - nstr_q);
        end else begin
          idx_sel_s = IW'(chk_sum_s);
        end
      end
      default:      idx_sel_s = '0;
    endcase
  end

  // FSM next state and registered write-port outputs.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        if (iStart) begin
          busy_d = 1'b1;
          if (empty_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
            wr_en_d = 1'b1;
            col_d   = iX0;
            row_d   = iY0;
            addr_d  = pixel_addr(iY0, iX0);
            data_d  = iColorTable[COLOR_W-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (iWrReady) begin
          if (last_s) begin
            state_d = ST_DONE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (row_end_s) begin
              col_d = x0_q;
              row_d = row_q + YW'(1);
            end else begin
              col_d = col_q + XW'(1);
            end
            addr_d = pixel_addr(row_d, col_d);
            data_d = table_entry(table_q, idx_sel_s);
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, position and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Fill parameters are captured once at start so later input changes are inert.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mode_q  <= FILL_SOLID;
      table_q <= '0;
      nstr_q  <= NW'(1);
      sw_q    <= XW'(1);
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else if (start_s) begin
      mode_q  <= fill_mode_e'(iMode);
      table_q <= iColorTable;
      nstr_q  <= nstr_in_s;
      sw_q    <= sw_in_s;
      x0_q    <= iX0;
      x1_q    <= x1_clamp_s;
      y1_q    <= y1_clamp_s;
    end else begin
      mode_q  <= mode_q;
      table_q <= table_q;
      nstr_q  <= nstr_q;
      sw_q    <= sw_q;
      x0_q    <= x0_q;
      x1_q    <= x1_q;
      y1_q    <= y1_q;
    end
  end

  assign oWrEn   = wr_en_q;
  assign oWrAddr = addr_q;
  assign oWrData = data_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_vga_pattern_fill.sv
// Scoreboard bench for vga_pattern_fill: a raster model queues expected writes,
// a monitor pops and compares each accepted write; scenario tasks check timing.
module tb_vga_pattern_fill;
  import vga_pattern_fill_pkg::*;

  localparam int COLS = 256, ROWS = 48, COLOR_W = 3, NSTRIPES = 4;
  localparam int XW = 8, YW = 6, AW = 14;

  typedef struct packed {
    logic [AW-1:0]      addr;
    logic [COLOR_W-1:0] data;
  } pix_t;

  logic                        Clock = 1'b0;
  logic                        Reset = 1'b0;
  logic                        iStart = 1'b0;
  logic [1:0]                  iMode = '0;
  logic [NSTRIPES*COLOR_W-1:0] iColorTable = '0;
  logic [2:0]                  iNumStripes = '0;
  logic [XW-1:0]               iStripeW = '0, iX0 = '0, iX1 = '0;
  logic [YW-1:0]               iY0 = '0, iY1 = '0;
  logic                        iWrReady = 1'b1;
  logic                        oWrEn, oBusy, oDone;
  logic [AW-1:0]               oWrAddr;
  logic [COLOR_W-1:0]          oWrData;

  pix_t               exp_q[$];
  int                 total = 0, bad = 0, wr_seen = 0;
  bit                 mon_en = 1'b0;
  logic [AW-1:0]      last_addr = '0;

  always #5 Clock = ~Clock;

  vga_pattern_fill #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W), .NSTRIPES(NSTRIPES),
                     .XW(XW), .YW(YW), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iMode(iMode),
    .iColorTable(iColorTable), .iNumStripes(iNumStripes), .iStripeW(iStripeW),
    .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1), .iWrReady(iWrReady),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .oBusy(oBusy), .oDone(oDone)
  );

  // Monitor: pop on every accepted write, and check held outputs after a stall.
  initial begin
    pix_t          e;
    bit            stall = 1'b0;
    logic [AW-1:0] h_addr;
    logic [COLOR_W-1:0] h_data;
    forever begin
      @(negedge Clock);
      if (mon_en) begin
        if (stall) begin
          total++;
          if (oWrEn !== 1'b1 || oWrAddr !== h_addr || oWrData !== h_data) begin
            bad++;
            $display("FAIL hold: got en=%b addr=%0d data=%0d, want en=1 addr=%0d data=%0d",
                     oWrEn, oWrAddr, oWrData, h_addr, h_data);
          end
        end
        stall  = (oWrEn === 1'b1 && iWrReady === 1'b0);
        h_addr = oWrAddr;
        h_data = oWrData;
        if (oWrEn === 1'b1 && iWrReady === 1'b1) begin
          wr_seen++;
          last_addr = oWrAddr;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_write: got addr=%0d data=%0d, want no write", oWrAddr, oWrData);
          end else begin
            e = exp_q.pop_front();
            if (oWrAddr !== e.addr || oWrData !== e.data) begin
              bad++;
              $display("FAIL pixel: got addr=%0d data=%0d, want addr=%0d data=%0d",
                       oWrAddr, oWrData, e.addr, e.data);
            end
          end
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Reference raster walk: stripe index from distance to the region origin.
  task automatic push_fill(input int mode, input logic [11:0] tbl, input int ns, input int sw,
                           input int x0, input int x1, input int y0, input int y1,
                           output int n);
    int ne, swe, x1c, y1c, xs, ys, idx;
    pix_t p;
    ne  = (ns == 0) ? 1 : ((ns > NSTRIPES) ? NSTRIPES : ns);
    swe = (sw == 0) ? 1 : sw;
    x1c = (x1 > COLS - 1) ? COLS - 1 : x1;
    y1c = (y1 > ROWS - 1) ? ROWS - 1 : y1;
    n = 0;
    for (int r = y0; r <= y1c; r++) begin
      for (int c = x0; c <= x1c; c++) begin
        xs = ((c - x0) / swe) % ne;
        ys = ((r - y0) / swe) % ne;
        case (mode)
          0:       idx = 0;
          1:       idx = xs;
          2:       idx = ys;
          default: idx = (xs + ys) % ne;
        endcase
        p.addr = AW'(r * COLS + c);
        p.data = tbl[idx*COLOR_W +: COLOR_W];
        exp_q.push_back(p);
        n++;
      end
    end
  endtask

  // Drive a one-cycle start; returns just after the sampling edge T.
  task automatic launch(input int mode, input logic [11:0] tbl, input int ns, input int sw,
                        input int x0, input int x1, input int y0, input int y1);
    @(posedge Clock); #1;
    iMode = 2'(mode); iColorTable = tbl; iNumStripes = 3'(ns); iStripeW = XW'(sw);
    iX0 = XW'(x0); iX1 = XW'(x1); iY0 = YW'(y0); iY1 = YW'(y1);
    iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
  endtask

  // Cycles after T until oDone is seen; -1 when the budget runs out.
  task automatic wait_done(input int limit, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge Clock);
      cyc++;
      if (oDone === 1'b1) got = 1'b1;
    end
    if (!got) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    total++; if (oWrEn !== 1'b0)    begin bad++; $display("FAIL rst_wren: got %b want 0", oWrEn); end
    total++; if (oWrAddr !== '0)    begin bad++; $display("FAIL rst_addr: got %0d want 0", oWrAddr); end
    total++; if (oWrData !== '0)    begin bad++; $display("FAIL rst_data: got %0d want 0", oWrData); end
    total++; if (oBusy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", oBusy); end
    total++; if (oDone !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", oDone); end
    Reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_solid();
    int n, cyc, w0;
    logic [11:0] tbl = {COLOR_WHITE, COLOR_RED, COLOR_BLUE, COLOR_GREEN};
    w0 = wr_seen;
    push_fill(0, tbl, 4, 1, 0, 3, 0, 1, n);
    launch(0, tbl, 4, 1, 0, 3, 0, 1);
    total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL solid_busy_t1: got %b want 1", oBusy); end
    wait_done(50, cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL solid_done_lat: got %0d want 9", cyc); end
    total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL solid_busy_done: got %b want 1", oBusy); end
    @(negedge Clock);
    total++; if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      bad++; $display("FAIL solid_after: got done=%b busy=%b want 0 0", oDone, oBusy); end
    total++; if (wr_seen - w0 !== n || exp_q.size() != 0) begin
      bad++; $display("FAIL solid_count: got %0d writes want %0d", wr_seen - w0, n); end
  endtask

  task automatic test_vstripe();
    int n, cyc;
    logic [11:0] tbl = {COLOR_GREEN, COLOR_BLUE, COLOR_MAGENTA, COLOR_RED};
    push_fill(1, tbl, 4, 2, 0, 9, 0, 0, n);
    launch(1, tbl, 4, 2, 0, 9, 0, 0);
    wait_done(50, cyc);
    total++; if (cyc !== n + 1) begin bad++; $display("FAIL vstripe_lat: got %0d want %0d", cyc, n + 1); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL vstripe_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_hstripe_checker();
    int n, cyc;
    logic [11:0] tbl = {COLOR_YELLOW, COLOR_CYAN, COLOR_WHITE, COLOR_RED};
    push_fill(2, tbl, 3, 2, 10, 11, 2, 6, n);
    launch(2, tbl, 3, 2, 10, 11, 2, 6);
    wait_done(50, cyc);
    total++; if (cyc !== n + 1) begin bad++; $display("FAIL hstripe_lat: got %0d want %0d", cyc, n + 1); end
    push_fill(3, tbl, 2, 1, 0, 1, 0, 1, n);
    launch(3, tbl, 2, 1, 0, 1, 0, 1);
    wait_done(50, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL checker_lat: got %0d want 5", cyc); end
    // NumStripes 7 clamps to 4, StripeW 3 spans several stripes per axis.
    push_fill(3, tbl, 7, 3, 3, 14, 1, 7, n);
    launch(3, tbl, 7, 3, 3, 14, 1, 7);
    wait_done(200, cyc);
    total++; if (cyc !== n + 1) begin bad++; $display("FAIL checker_clamp_lat: got %0d want %0d", cyc, n + 1); end
    // NumStripes 0 and StripeW 0 behave as 1.
    push_fill(1, tbl, 0, 0, 40, 45, 3, 3, n);
    launch(1, tbl, 0, 0, 40, 45, 3, 3);
    wait_done(50, cyc);
    total++; if (exp_q.size() != 0 || cyc !== n + 1) begin
      bad++; $display("FAIL zero_params: got left=%0d lat=%0d want 0 %0d", exp_q.size(), cyc, n + 1); end
  endtask

  task automatic test_backpressure();
    int n, cyc;
    bit got = 1'b0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [11:0] tbl = {COLOR_GREEN, COLOR_BLUE, COLOR_MAGENTA, COLOR_RED};
    push_fill(1, tbl, 4, 1, 100, 105, 10, 11, n);
    launch(1, tbl, 4, 1, 100, 105, 10, 11);
    cyc = 0;
    iWrReady = pat[0];
    while (!got && cyc < 100) begin
      @(negedge Clock);
      cyc++;
      if (oDone === 1'b1) got = 1'b1;
      @(posedge Clock); #1;
      iWrReady = pat[cyc % 4];
    end
    iWrReady = 1'b1;
    total++; if (!got || cyc !== 25) begin bad++; $display("FAIL bp_lat: got %0d want 25", cyc); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    int n, cyc;
    logic [11:0] tbl = {COLOR_GREEN, COLOR_BLUE, COLOR_MAGENTA, COLOR_RED};
    push_fill(1, tbl, 4, 1, 0, 7, 3, 3, n);
    launch(1, tbl, 4, 1, 0, 7, 3, 3);
    @(posedge Clock); #1;
    iStart = 1'b1; iMode = 2'd0; iX0 = 8'd50; iColorTable = 12'hFFF;
    repeat (2) @(posedge Clock);
    #1 iStart = 1'b0;
    wait_done(50, cyc);
    total++; if (cyc !== 6) begin bad++; $display("FAIL restart_lat: got %0d want 6", cyc); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_clamp_empty();
    int n, cyc, w0;
    logic [11:0] tbl = {COLOR_GREEN, COLOR_BLUE, COLOR_MAGENTA, COLOR_RED};
    push_fill(1, tbl, 2, 2, 250, 255, 45, 60, n);
    launch(1, tbl, 2, 2, 250, 255, 45, 60);
    wait_done(100, cyc);
    total++; if (cyc !== 19) begin bad++; $display("FAIL clamp_lat: got %0d want 19", cyc); end
    total++; if (last_addr !== AW'(47 * COLS + 255)) begin
      bad++; $display("FAIL clamp_last: got %0d want %0d", last_addr, 47 * COLS + 255); end
    w0 = wr_seen;
    launch(0, tbl, 1, 1, 5, 4, 0, 0);
    wait_done(10, cyc);
    total++; if (cyc < 1 || cyc > 2) begin bad++; $display("FAIL empty_x_lat: got %0d want 1..2", cyc); end
    launch(0, tbl, 1, 1, 0, 3, 10, 3);
    wait_done(10, cyc);
    total++; if (cyc < 1 || cyc > 2) begin bad++; $display("FAIL empty_y_lat: got %0d want 1..2", cyc); end
    @(negedge Clock);
    total++; if (wr_seen != w0 || oBusy !== 1'b0) begin
      bad++; $display("FAIL empty_writes: got %0d busy=%b want 0 0", wr_seen - w0, oBusy); end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    bit saw_done = 1'b0;
    logic [11:0] tbl = {COLOR_GREEN, COLOR_BLUE, COLOR_MAGENTA, COLOR_CYAN};
    push_fill(1, tbl, 4, 1, 0, 9, 0, 0, n);
    launch(1, tbl, 4, 1, 0, 9, 0, 0);
    repeat (3) @(negedge Clock);
    @(posedge Clock); #2;
    mon_en = 1'b0;
    Reset = 1'b0;
    #1;
    total++; if (oWrEn !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctl: got en=%b busy=%b done=%b want 0 0 0", oWrEn, oBusy, oDone); end
    total++; if (oWrAddr !== '0 || oWrData !== '0) begin
      bad++; $display("FAIL mid_rst_bus: got addr=%0d data=%0d want 0 0", oWrAddr, oWrData); end
    total++; if (exp_q.size() != 7) begin bad++; $display("FAIL mid_rst_consumed: got %0d left want 7", exp_q.size()); end
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (4) begin
      @(negedge Clock);
      if (oDone === 1'b1 || oWrEn === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL mid_rst_quiet: got activity want none"); end
    mon_en = 1'b1;
    push_fill(1, tbl, 4, 1, 0, 9, 0, 0, n);
    launch(1, tbl, 4, 1, 0, 9, 0, 0);
    wait_done(50, cyc);
    total++; if (cyc !== 11 || exp_q.size() != 0) begin
      bad++; $display("FAIL mid_rst_restart: got lat=%0d left=%0d want 11 0", cyc, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_vstripe();
    test_hstripe_checker();
    test_backpressure();
    test_start_ignored();
    test_clamp_empty();
    test_reset_mid();
    repeat (2) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
